// File: rtl/ppm_frame_ctrl_if.sv
// Payload byte stream from ppm_frame_ctrl to its consumer.
//   out_valid : payload byte available
//   out_data  : payload byte
//   out_last  : out_data is the final payload byte of the frame
//   out_ready : consumer accepts the byte when out_valid && out_ready
// master = frame controller (producer), slave = consumer.
interface ppm_frame_ctrl_if;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/ppm_frame_ctrl.sv
// Frame-level sequencer for the 4-PPM receive path.
// Hunts the 2-bit symbol stream for SYNC_WORD, then reads a length byte and
// the payload from the downstream byte assembler. It gates and clears the
// assembler and hands payload bytes out over a single-entry valid/ready
// register. Aborts on symbol error, consumer overflow, symbol-gap timeout
// and zero length.
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   enable           receiver enable; low forces IDLE
//   clk16            16x symbol-rate tick; qualifies sym_valid / sym_err
//   sym_valid/data   decoded symbol
//   sym_err          invalid pulse pattern
//   asm_sym_en       symbol strobe forwarded to the byte assembler
//   asm_clr          one-cycle assembler clear
//   asm_byte_valid   assembler byte complete (pulse), asm_byte its value
//   out_if           payload stream (master side)
//   frame_start      pulse on sync match
//   frame_done       pulse the cycle after the last byte is accepted
//   frame_err        pulse on abort; err_code holds the cause until next start
//   busy             high in LEN, DATA, DRAIN
module ppm_frame_ctrl #(
    parameter logic [7:0] SYNC_WORD = 8'hA5,
    parameter int unsigned GAP_TICKS = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   clk16,
    input  logic                   sym_valid,
    input  logic [1:0]             sym_data,
    input  logic                   sym_err,
    output logic                   asm_sym_en,
    output logic                   asm_clr,
    input  logic                   asm_byte_valid,
    input  logic [7:0]             asm_byte,
    ppm_frame_ctrl_if.master       out_if,
    output logic                   frame_start,
    output logic                   frame_done,
    output logic                   frame_err,
    output logic [1:0]             err_code,
    output logic                   busy
);

    localparam int unsigned GW = $clog2(GAP_TICKS + 1);

    localparam logic [1:0] ERR_ZERO = 2'b00;
    localparam logic [1:0] ERR_SYM  = 2'b01;
    localparam logic [1:0] ERR_OVF  = 2'b10;
    localparam logic [1:0] ERR_TO   = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        LEN   = 3'd2,
        DATA  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [7:0]      window, window_nxt;
    logic [7:0]      remaining, rem_nxt;
    logic [GW-1:0]   gap_cnt, gap_nxt, gap_inc;
    logic            out_valid_q, out_last_q;
    logic [7:0]      out_data_q;

    logic            sym_stb, err_stb, accept;
    logic            abort, load, start, done, clr_pulse;
    logic [1:0]      abort_code;
    logic            e_sym, e_ovf, e_to, e_zero;
    logic [7:0]      window_shift;

    assign sym_stb      = clk16 & sym_valid;
    assign err_stb      = clk16 & sym_err;
    assign accept       = out_valid_q & out_if.out_ready;
    assign gap_inc      = gap_cnt + 1'b1;
    assign window_shift = {window[5:0], sym_data};

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_last  = out_last_q;

    // Erroneous symbols never reach the assembler.
    assign asm_sym_en = sym_stb & ~err_stb & ((state == LEN) | (state == DATA));
    assign busy       = (state == LEN) | (state == DATA) | (state == DRAIN);

    always_comb begin
        state_nxt  = state;
        window_nxt = window;
        rem_nxt    = remaining;
        gap_nxt    = gap_cnt;
        abort      = 1'b0;
        abort_code = ERR_ZERO;
        load       = 1'b0;
        start      = 1'b0;
        done       = 1'b0;
        clr_pulse  = 1'b0;
        e_sym      = 1'b0;
        e_ovf      = 1'b0;
        e_to       = 1'b0;
        e_zero     = 1'b0;

        if (!enable) begin
            state_nxt = IDLE;
            clr_pulse = (state != IDLE);
        end else begin
            case (state)
                IDLE: begin
                    state_nxt  = SYNC;
                    clr_pulse  = 1'b1;
                    window_nxt = '0;
                end
                SYNC: begin
                    if (sym_stb) begin
                        window_nxt = window_shift;
                        if (window_shift == SYNC_WORD) begin
                            start     = 1'b1;
                            clr_pulse = 1'b1;
                            gap_nxt   = '0;
                            state_nxt = LEN;
                        end
                    end
                end
                LEN, DATA: begin
                    if (sym_stb)
                        gap_nxt = '0;
                    else if (clk16)
                        gap_nxt = gap_inc;

                    e_sym  = err_stb;
                    e_ovf  = (state == DATA) & asm_byte_valid & out_valid_q & ~out_if.out_ready;
                    e_to   = clk16 & ~sym_stb & (gap_inc == GW'(GAP_TICKS));
                    e_zero = (state == LEN) & asm_byte_valid & (asm_byte == 8'd0);

                    abort = e_sym | e_ovf | e_to | e_zero;
                    if (e_sym)
                        abort_code = ERR_SYM;
                    else if (e_ovf)
                        abort_code = ERR_OVF;
                    else if (e_to)
                        abort_code = ERR_TO;
                    else
                        abort_code = ERR_ZERO;

                    if (abort) begin
                        state_nxt  = SYNC;
                        window_nxt = '0;
                        clr_pulse  = 1'b1;
                    end else if (asm_byte_valid) begin
                        if (state == LEN) begin
                            rem_nxt   = asm_byte;
                            state_nxt = DATA;
                        end else begin
                            load    = 1'b1;
                            rem_nxt = remaining - 8'd1;
                            if (remaining == 8'd1)
                                state_nxt = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        done       = 1'b1;
                        state_nxt  = SYNC;
                        window_nxt = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            window      <= '0;
            remaining   <= '0;
            gap_cnt     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= '0;
            asm_clr     <= 1'b0;
        end else begin
            state       <= state_nxt;
            window      <= window_nxt;
            remaining   <= rem_nxt;
            gap_cnt     <= gap_nxt;
            frame_start <= start;
            frame_done  <= done;
            frame_err   <= abort;
            asm_clr     <= clr_pulse;

            if (start)
                err_code <= '0;
            else if (abort)
                err_code <= abort_code;

            // A new byte loaded in the same cycle as an accept replaces the old one.
            if (!enable || abort) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= asm_byte;
                out_last_q  <= (remaining == 8'd1);
            end else if (accept) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

endmodule
